maze_navigator: RTL
===================

# maze_navigator

Parametrised maze-solving controller for the line-following car. It replaces the fixed straight/choose FSM with a junction-aware navigator. The block classifies an N-wide tracker pattern and records each junction decision on an internal stack. On a dead end it backtracks and takes the next untried branch. It sits between `tracker_sensor`/`sonic_top` and `motor`, and drives `motor` through an encoded mode.

## Interface
- `SENSOR_W`, 3: tracker width; odd, ≥3; centre bit is `SENSOR_W/2`.
- `STACK_DEPTH`, 16: maximum number of recorded junctions.
- `START_DLY`, 100_000_000: countdown cycles between arming and motion.
- `DEBOUNCE`, 4: consecutive identical cycles required before a pattern is classified.
- `TURN_MAX`, 200_000_000: turn/spin timeout in cycles.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  run switch; low returns the block to IDLE.
- `detect`  in  SENSOR_W  tracker pattern; 1 means line.
- `obstacle`  in  1  sonar distance is below the stop threshold (compared externally).
- `mode`  out  3  motor command: 0 STOP, 1 FWD, 2 STEER_L, 3 STEER_R, 4 TURN_L, 5 TURN_R, 6 SPIN.
- `state_o`  out  4  current state code, used for the LED decode.
- `depth`  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- `err`  out  1  high while in ERROR.
- `flash`  out  1  toggles every START_DLY/8 cycles while in COUNT.

## Operation
Pattern classes:
- CENTRE: only the centre bit set.
- ALL: all bits set; this is a junction.
- NONE: all bits clear; this is a dead end.
- LEFT_BIAS: set bits lie only at index > centre.
- RIGHT_BIAS: set bits lie only at index < centre.
- OTHER: anything else.

Steering uses the raw `detect`. Junction and dead-end decisions use the debounced class only.

States:
- IDLE (0): mode STOP, stack cleared. `enable` → ARM.
- ARM (1): mode STOP. Debounced CENTRE → COUNT.
- COUNT (2): mode STOP, `flash` active. After START_DLY cycles → FOLLOW.
- FOLLOW (3):
  - mode FWD on CENTRE/OTHER, STEER_L on LEFT_BIAS, STEER_R on RIGHT_BIAS.
  - Debounced ALL → JUNCTION.
  - Debounced NONE → BACKTRACK.
- JUNCTION (4), one cycle:
  - Forward pass: push choice LEFT(0), then → TURN.
  - Returning from BACKTRACK: pop top t.
    - If t < RIGHT(2): push t+1, then → TURN.
    - If t = RIGHT: → BACKTRACK (the branch is exhausted).
- TURN (5):
  - mode TURN_L for choice 0, FWD for choice 1, TURN_R for choice 2.
  - Debounced CENTRE, entered after leaving the ALL pattern → FOLLOW.
- BACKTRACK (6):
  - mode SPIN until debounced CENTRE.
  - Then FOLLOW with the return flag set. The flag clears on the next JUNCTION.
- ERROR (15): mode STOP, `err`=1. Leaves only on `enable` low → IDLE.

Error conditions:
- Push while `depth`==STACK_DEPTH (overflow) → ERROR, and the push is dropped.
- Pop while `depth`==0 → ERROR.
- TURN or BACKTRACK lasting TURN_MAX cycles → ERROR.
- `enable` low in any state → IDLE next cycle and the stack is cleared. This has priority over every other transition.

## Timing
- Reset values: state IDLE; `mode` 0; `depth` 0; `err` 0; `flash` 0; all counters 0.
- `mode`, `err`, `flash` and `state_o` are registered. Each reflects the state and pattern one cycle after the input change.
- The debounce counter restarts on any change of `detect`. A class is valid on the DEBOUNCE-th identical cycle.
- A push or pop takes effect on the JUNCTION cycle, so `depth` updates on the following edge. The pop and the push of the same JUNCTION are one atomic read-modify-write: `depth` is unchanged and the top entry is replaced.
- Counters saturate; they never wrap.
- `rst` asserted mid-turn forces all outputs to their reset values immediately (asynchronous). Outputs stay there until `rst` deasserts and the first clk edge follows.

## Configuration
- `MAZE_OBSTACLE_STOP_EN`
  - Defined: a PAUSE state (7) exists. `obstacle` high in FOLLOW, TURN or BACKTRACK → PAUSE with mode STOP and all counters frozen. When `obstacle` is low for DEBOUNCE cycles, the block returns to the saved state.
  - Undefined: `obstacle` is ignored and PAUSE does not exist.

## Structure
- `maze_pkg` holds:
  - the state codes,
  - the mode codes (shared with `motor`),
  - the choice codes LEFT/STRAIGHT/RIGHT,
  - the pattern-class enum.
- Sub-module `pattern_classifier`: debounce counter plus class decode, parametrised by SENSOR_W and DEBOUNCE.
- The stack is a 2-bit × STACK_DEPTH register array inside `maze_navigator`.

## Test plan
Bench parameters: SENSOR_W=3, DEBOUNCE=2, START_DLY=8, STACK_DEPTH=2, TURN_MAX=50.
- Start-up: `enable`=1, `detect`=010 held → ARM, then COUNT for 8 cycles with `flash` toggling, then FOLLOW with `mode`=1.
- Steering: in FOLLOW, `detect`=100 → `mode`=2 one cycle later; `detect`=001 → `mode`=3. A single-cycle 111 glitch must not enter JUNCTION.
- Junction then dead end: 111×2 → `depth`=1 and `mode`=4; 010×2 → FOLLOW; 000×2 → `mode`=6; 010×2, then 111×2 → top=1 and `mode`=1 with `depth` still 1.
- Exhaustion: the top entry reaches 2 and another dead end returns to that junction → pop, re-enter BACKTRACK; with `depth`=0 → `err`=1 and `mode`=0.
- Limits: three junctions with no dead end → ERROR on the third push. TURN held at 111 for 50 cycles → ERROR. `enable` low → IDLE and `depth`=0.
- With `MAZE_OBSTACLE_STOP_EN` defined: `obstacle`=1 in FOLLOW → `mode`=0; clearing it for 2 cycles → FOLLOW resumes with the stack unchanged.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: state, motor-mode, junction-choice and pattern-class codes for the navigator.
// MAZE_OBSTACLE_STOP_EN adds the PAUSE state used for sonar obstacle stops.
package maze_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ARM       = 4'd1,
        ST_COUNT     = 4'd2,
        ST_FOLLOW    = 4'd3,
        ST_JUNCTION  = 4'd4,
        ST_TURN      = 4'd5,
        ST_BACKTRACK = 4'd6,
`ifdef MAZE_OBSTACLE_STOP_EN
        ST_PAUSE     = 4'd7,
`endif
        ST_ERROR     = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        M_STOP    = 3'd0,
        M_FWD     = 3'd1,
        M_STEER_L = 3'd2,
        M_STEER_R = 3'd3,
        M_TURN_L  = 3'd4,
        M_TURN_R  = 3'd5,
        M_SPIN    = 3'd6
    } mode_e;

    typedef enum logic [1:0] {
        CH_LEFT     = 2'd0,
        CH_STRAIGHT = 2'd1,
        CH_RIGHT    = 2'd2
    } choice_e;

    typedef enum logic [2:0] {
        PC_CENTRE     = 3'd0,
        PC_ALL        = 3'd1,
        PC_NONE       = 3'd2,
        PC_LEFT_BIAS  = 3'd3,
        PC_RIGHT_BIAS = 3'd4,
        PC_OTHER      = 3'd5
    } pclass_e;

    function automatic mode_e turn_mode(input choice_e c);
        unique case (c)
            CH_LEFT:     turn_mode = M_TURN_L;
            CH_STRAIGHT: turn_mode = M_FWD;
            CH_RIGHT:    turn_mode = M_TURN_R;
            default:     turn_mode = M_STOP;
        endcase
    endfunction

endpackage

// File: rtl/maze_navigator_classifier.sv
// pattern_classifier: decodes the raw tracker pattern into a class and flags
// it valid once the same pattern has been seen DEBOUNCE cycles in a row.
module pattern_classifier
    import maze_pkg::*;
#(
    parameter int SENSOR_W = 3,
    parameter int DEBOUNCE = 4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [SENSOR_W-1:0] detect,
    output pclass_e             cls_o,
    output logic                valid_o
);

    localparam int C  = SENSOR_W / 2;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [SENSOR_W-1:0] CMASK  = SENSOR_W'(1) << C;
    localparam logic [SENSOR_W-1:0] LOMASK = CMASK - SENSOR_W'(1);
    localparam logic [SENSOR_W-1:0] HIMASK = ~(LOMASK | CMASK);

    logic [SENSOR_W-1:0] prev_q, prev_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic same, is_none, is_all, is_ctr, is_lb, is_rb;

    always_comb begin
        same   = (detect == prev_q);
        prev_d = detect;
        cnt_d  = CW'(1);
        if (same)
            cnt_d = (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
        // cnt_q counts earlier identical cycles; this cycle is one more
        valid_o = (DEBOUNCE <= 1) || (same && cnt_q >= CW'(DEBOUNCE - 1));

        is_none = (detect == '0);
        is_all  = (detect == {SENSOR_W{1'b1}});
        is_ctr  = (detect == CMASK);
        is_lb   = !is_none && ((detect & ~HIMASK) == '0);
        is_rb   = !is_none && ((detect & ~LOMASK) == '0);

        cls_o = PC_OTHER;
        unique case (1'b1)
            is_none: cls_o = PC_NONE;
            is_all:  cls_o = PC_ALL;
            is_ctr:  cls_o = PC_CENTRE;
            is_lb:   cls_o = PC_LEFT_BIAS;
            is_rb:   cls_o = PC_RIGHT_BIAS;
            default: cls_o = PC_OTHER;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/maze_navigator.sv
// maze_navigator: junction-aware line-follower controller with a choice stack
// for backtracking. MAZE_OBSTACLE_STOP_EN enables the obstacle PAUSE state.
module maze_navigator
    import maze_pkg::*;
#(
    parameter int SENSOR_W    = 3,
    parameter int STACK_DEPTH = 16,
    parameter int START_DLY   = 100_000_000,
    parameter int DEBOUNCE    = 4,
    parameter int TURN_MAX    = 200_000_000
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [SENSOR_W-1:0]                detect,
    input  logic                               obstacle,
    output logic [2:0]                         mode,
    output logic [3:0]                         state_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               err,
    output logic                               flash
);

    localparam int TMAX = (START_DLY > TURN_MAX) ? START_DLY : TURN_MAX;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FL   = (START_DLY / 8 > 0) ? START_DLY / 8 : 1;
    localparam int FW   = $clog2(FL + 1);
    localparam int DW   = $clog2(STACK_DEPTH + 1);

    state_e                   state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [FW-1:0]            fcnt_q, fcnt_d;
    logic [DW-1:0]            depth_q, depth_d;
    logic [2*STACK_DEPTH-1:0] stack_q, stack_d;
    choice_e                  choice_q, choice_d, top;
    logic                     ret_q, ret_d, left_q, left_d;
    mode_e                    mode_q, mode_d;
    logic                     err_q, err_d, flash_q, flash_d;
    pclass_e                  cls;
    logic                     valid;
    int                       tidx;

`ifdef MAZE_OBSTACLE_STOP_EN
    localparam int PW = $clog2(DEBOUNCE + 1);
    state_e        save_q, save_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
`else
    logic unused_obstacle;
    assign unused_obstacle = obstacle;
`endif

    pattern_classifier #(
        .SENSOR_W (SENSOR_W),
        .DEBOUNCE (DEBOUNCE)
    ) u_cls (
        .clk     (clk),
        .rst     (rst),
        .detect  (detect),
        .cls_o   (cls),
        .valid_o (valid)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fcnt_d   = fcnt_q;
        depth_d  = depth_q;
        stack_d  = stack_q;
        choice_d = choice_q;
        ret_d    = ret_q;
        left_d   = left_q;
        flash_d  = 1'b0;
`ifdef MAZE_OBSTACLE_STOP_EN
        save_d   = save_q;
        pcnt_d   = pcnt_q;
`endif
        tidx = (depth_q == '0) ? 0 : int'(depth_q) - 1;
        top  = choice_e'(stack_q[2*tidx +: 2]);

        if (!enable) begin
            state_d = ST_IDLE;
            depth_d = '0;
            ret_d   = 1'b0;
`ifdef MAZE_OBSTACLE_STOP_EN
        end else if (obstacle && (state_q inside {ST_FOLLOW, ST_TURN, ST_BACKTRACK})) begin
            state_d = ST_PAUSE;
            save_d  = state_q;
            pcnt_d  = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    depth_d = '0;
                    ret_d   = 1'b0;
                    state_d = ST_ARM;
                end
                ST_ARM:
                    if (valid && cls == PC_CENTRE) state_d = ST_COUNT;
                ST_COUNT:
                    if (timer_q == TW'(START_DLY - 1)) state_d = ST_FOLLOW;
                ST_FOLLOW: begin
                    if (valid && cls == PC_ALL)       state_d = ST_JUNCTION;
                    else if (valid && cls == PC_NONE) state_d = ST_BACKTRACK;
                end
                ST_JUNCTION: begin
                    ret_d  = 1'b0;
                    left_d = 1'b0;
                    if (!ret_q) begin
                        if (depth_q == DW'(STACK_DEPTH)) begin
                            state_d = ST_ERROR;
                        end else begin
                            stack_d[2*int'(depth_q) +: 2] = CH_LEFT;
                            depth_d  = depth_q + 1'b1;
                            choice_d = CH_LEFT;
                            state_d  = ST_TURN;
                        end
                    end else if (depth_q == '0) begin
                        state_d = ST_ERROR;
                    end else if (top != CH_RIGHT) begin
                        // pop and push collapse into an in-place update
                        choice_d = choice_e'(top + 2'd1);
                        stack_d[2*tidx +: 2] = choice_d;
                        state_d  = ST_TURN;
                    end else begin
                        depth_d = depth_q - 1'b1;
                        state_d = ST_BACKTRACK;
                    end
                end
                ST_TURN: begin
                    if (detect != {SENSOR_W{1'b1}}) left_d = 1'b1;
                    if (timer_q == TW'(TURN_MAX - 1))
                        state_d = ST_ERROR;
                    else if (valid && cls == PC_CENTRE && left_q)
                        state_d = ST_FOLLOW;
                end
                ST_BACKTRACK: begin
                    if (timer_q == TW'(TURN_MAX - 1)) begin
                        state_d = ST_ERROR;
                    end else if (valid && cls == PC_CENTRE) begin
                        state_d = ST_FOLLOW;
                        ret_d   = 1'b1;
                    end
                end
`ifdef MAZE_OBSTACLE_STOP_EN
                ST_PAUSE: begin
                    if (obstacle)
                        pcnt_d = '0;
                    else if (pcnt_q == PW'(DEBOUNCE - 1))
                        state_d = save_q;
                    else
                        pcnt_d = pcnt_q + 1'b1;
                end
`endif
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end

        // timers survive a pause so a resumed turn keeps its timeout budget
`ifdef MAZE_OBSTACLE_STOP_EN
        if (state_d != state_q && state_d != ST_PAUSE && state_q != ST_PAUSE)
`else
        if (state_d != state_q)
`endif
            timer_d = '0;
        else if ((state_q inside {ST_COUNT, ST_TURN, ST_BACKTRACK}) && timer_q != '1)
            timer_d = timer_q + 1'b1;

        if (state_d == ST_COUNT) begin
            if (state_q != ST_COUNT) begin
                flash_d = 1'b1;
                fcnt_d  = '0;
            end else if (fcnt_q == FW'(FL - 1)) begin
                flash_d = ~flash_q;
                fcnt_d  = '0;
            end else begin
                flash_d = flash_q;
                fcnt_d  = fcnt_q + 1'b1;
            end
        end

        unique case (state_d)
            ST_FOLLOW: begin
                if (cls == PC_LEFT_BIAS)       mode_d = M_STEER_L;
                else if (cls == PC_RIGHT_BIAS) mode_d = M_STEER_R;
                else                           mode_d = M_FWD;
            end
            ST_JUNCTION:  mode_d = M_FWD;
            ST_TURN:      mode_d = turn_mode(choice_d);
            ST_BACKTRACK: mode_d = M_SPIN;
            default:      mode_d = M_STOP;
        endcase
        err_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            fcnt_q   <= '0;
            depth_q  <= '0;
            stack_q  <= '0;
            choice_q <= CH_LEFT;
            ret_q    <= 1'b0;
            left_q   <= 1'b0;
            mode_q   <= M_STOP;
            err_q    <= 1'b0;
            flash_q  <= 1'b0;
`ifdef MAZE_OBSTACLE_STOP_EN
            save_q   <= ST_IDLE;
            pcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            fcnt_q   <= fcnt_d;
            depth_q  <= depth_d;
            stack_q  <= stack_d;
            choice_q <= choice_d;
            ret_q    <= ret_d;
            left_q   <= left_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            flash_q  <= flash_d;
`ifdef MAZE_OBSTACLE_STOP_EN
            save_q   <= save_d;
            pcnt_q   <= pcnt_d;
`endif
        end
    end

    assign mode    = mode_q;
    assign state_o = state_q;
    assign depth   = depth_q;
    assign err     = err_q;
    assign flash   = flash_q;

endmodule
